uart_cmd_bridge: RTL and testbench
==================================

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter DATA_BYTES, default 4, SHALL set bytes per bus data word (bus width DATA_W = 8*DATA_BYTES).
REQ-002 Parameter ADDR_BYTES, default 2, SHALL set address bytes per frame (ADDR_W = 8*ADDR_BYTES).
REQ-003 Parameter NUM_DEV, default 4, range 1..255, SHALL set the number of addressable devices.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the inter-byte timeout in clocks.
REQ-005 iGlobalClock  in  1  sole clock; all logic on its rising edge.
REQ-006 iGlobalReset  in  1  reset, synchronous, active-high.
REQ-007 iUartByteAvailable  in  1  RX byte valid level; may stay high for many cycles.
REQ-008 iUartRx  in  8  RX byte, stable while iUartByteAvailable is high.
REQ-009 oUartTx  out  8  TX byte.
REQ-010 oUartTxByteAvailable  out  1  one-cycle TX strobe.
REQ-011 iUartTxBusy  in  1  transmitter busy; no strobe while high.
REQ-012 oBusWrite / oBusRead  out  1 each  request, held until iBusAck.
REQ-013 oBusDevSel  out  NUM_DEV  one-hot device select, valid with request.
REQ-014 oBusAddr  out  ADDR_W;  oBusData  out  DATA_W;  iBusData  in  DATA_W;  iBusAck  in  1.
REQ-015 oError  out  1  one-cycle pulse on protocol error.

Function
REQ-016 A byte SHALL be accepted only on the cycle after a 0->1 transition of iUartByteAvailable; a held-high level SHALL count as one byte.
REQ-017 Frame: CMD, DEV, ADDR_BYTES address bytes MSB first, then payload; CMD[7]=1 write, 0 read; CMD[6:0]=burst length minus 1 (1..128 words).
REQ-018 States: IDLE, DEV, ADDR, WDATA, WBUS, RBUS, RTX; IDLE->DEV on any byte; DEV->ADDR; ADDR->WDATA (write) or RBUS (read) after the last address byte.
REQ-019 WDATA SHALL assemble DATA_BYTES bytes MSB first, then go to WBUS asserting oBusWrite with the assembled word.
REQ-020 WBUS/RBUS SHALL hold the request, address, select and data stable until iBusAck; the request SHALL drop the cycle after ack.
REQ-021 RBUS SHALL capture iBusData on ack and go to RTX; RTX SHALL emit DATA_BYTES bytes MSB first, each strobe only when iUartTxBusy=0, with at least one idle cycle between strobes.
REQ-022 After each word, the address SHALL increment by 1 modulo 2^ADDR_W (wrap silently); after the last burst word, the FSM SHALL return to IDLE.
REQ-023 DEV >= NUM_DEV SHALL pulse oError; write payload is still consumed with no bus request; a read SHALL return to IDLE with no TX bytes.
REQ-024 Outside IDLE and RTX, no accepted byte for TIMEOUT_CYCLES clocks SHALL pulse oError and force IDLE, discarding partial words; bus and TX waits are exempt.
REQ-025 Bytes arriving during WBUS, RBUS or RTX SHALL be dropped and pulse oError.
REQ-026 oUartTxByteAvailable SHALL never be asserted in the same cycle as oBusWrite or oBusRead.

Reset
REQ-027 On iGlobalReset, the FSM SHALL return to IDLE and all outputs SHALL go to 0, including oBusDevSel, oBusAddr, oBusData and oUartTx.
REQ-028 Reset mid-frame or mid-request SHALL abort with no further strobe or request.
REQ-029 The edge detector SHALL reset to 1, so a level held high across reset release is not taken as a byte.

Structure
REQ-030 A shared package SHALL hold the state encoding, the CMD op-bit constants (UART_WRITE=1, UART_READ=0) and the burst field position.
REQ-031 The byte-to-word shift/serialise logic SHALL be one sub-module, uart_word_packer, parametrised by DATA_BYTES.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Write 0x80,0x01,0x00,0x07,'H','O','L','A' -> one oBusWrite, DevSel=0b0010, Addr=0x0007, Data=0x484F4C41.
- Read 0x00,0x01,0x00,0x07 with iBusData=0x484F4C41 -> TX bytes 0x48,0x4F,0x4C,0x41 in order; with iUartTxBusy held high for 20 cycles, the first strobe is delayed until busy falls.
- Write burst CMD=0x81 at address 0xFFFF with 8 data bytes -> writes to Addr 0xFFFF and then 0x0000.
- DEV=0x09 (NUM_DEV=4) write -> oError pulse, 4 data bytes consumed, no oBusWrite; the next valid frame succeeds.
- Stop after 2 data bytes -> oError at TIMEOUT_CYCLES; a byte held high 10 cycles counts as one byte; reset during WBUS drops oBusWrite the next cycle.

Source files
------------

// File: rtl/uart_cmd_bridge_pkg.sv
// Shared definitions for the UART command bridge: FSM encoding and CMD byte layout.
package uart_cmd_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEV   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_WBUS  = 3'd4,
    S_RBUS  = 3'd5,
    S_RTX   = 3'd6
  } state_t;

  // CMD[7] selects the operation, CMD[6:0] holds burst length minus one
  localparam logic        UART_WRITE = 1'b1;
  localparam logic        UART_READ  = 1'b0;
  localparam int unsigned CMD_OP_BIT = 7;
  localparam int unsigned BURST_MSB  = 6;
  localparam int unsigned BURST_LSB  = 0;
  localparam int unsigned BURST_W    = BURST_MSB - BURST_LSB + 1;

endpackage

// File: rtl/uart_word_packer.sv
// Byte <-> word shifter: assembles RX bytes MSB first and serialises a loaded word MSB first.
module uart_word_packer #(
  parameter  int unsigned DATA_BYTES = 4,
  localparam int unsigned DATA_W     = 8 * DATA_BYTES,
  localparam int unsigned CNT_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_shift_in,
  input  logic              i_load,
  input  logic              i_shift_out,
  input  logic [7:0]        i_byte,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_word,
  output logic [7:0]        o_msb,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [DATA_W-1:0] r_word;
  logic [CNT_W-1:0]  r_cnt;

  // Shift register with byte count; clear only empties the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= CNT_W'(DATA_BYTES);
    end else if (i_shift_in) begin
      r_word <= DATA_W'({r_word, i_byte});
      r_cnt  <= r_cnt + CNT_W'(1);
    end else if (i_shift_out) begin
      r_word <= DATA_W'({r_word, 8'h00});
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign o_word = r_word;
  assign o_msb  = r_word[DATA_W-1 -: 8];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: decodes CMD/DEV/ADDR/payload frames into bus read/write bursts.
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter  int unsigned DATA_BYTES     = 4,
  parameter  int unsigned ADDR_BYTES     = 2,
  parameter  int unsigned NUM_DEV        = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned DATA_W         = 8 * DATA_BYTES,
  localparam int unsigned ADDR_W         = 8 * ADDR_BYTES
) (
  input  logic               iGlobalClock,
  input  logic               iGlobalReset,
  input  logic               iUartByteAvailable,
  input  logic [7:0]         iUartRx,
  output logic [7:0]         oUartTx,
  output logic               oUartTxByteAvailable,
  input  logic               iUartTxBusy,
  output logic               oBusWrite,
  output logic               oBusRead,
  output logic [NUM_DEV-1:0] oBusDevSel,
  output logic [ADDR_W-1:0]  oBusAddr,
  output logic [DATA_W-1:0]  oBusData,
  input  logic [DATA_W-1:0]  iBusData,
  input  logic               iBusAck,
  output logic               oError
);

  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ACNT_W = $clog2(ADDR_BYTES + 1);
  localparam int unsigned CNT_W  = $clog2(DATA_BYTES + 1);

  state_t              r_state, w_state_nxt;
  logic                r_avail_q, r_byte_vld;
  logic [7:0]          r_byte;
  logic                r_op, r_dev_ok;
  logic [BURST_W-1:0]  r_burst;
  logic [7:0]          r_dev;
  logic [ACNT_W-1:0]   r_acnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [TMR_W-1:0]    r_timer;
  logic                r_tx_stb, r_bus_wr, r_bus_rd, r_err;
  logic [7:0]          r_tx_byte;
  logic [NUM_DEV-1:0]  r_devsel;
  logic [DATA_W-1:0]   r_bus_data;

  logic                w_rise, w_addr_last, w_word_last, w_timed, w_timeout, w_last_word;
  logic                w_dev_ok_c, w_tx_fire, w_tx_done;
  logic                w_err_c, w_pk_clear, w_pk_shift_in, w_pk_load, w_word_done;
  logic [DATA_W-1:0]   w_pk_word;
  logic [7:0]          w_pk_msb;
  logic [CNT_W-1:0]    w_pk_cnt;

  assign w_rise      = iUartByteAvailable & ~r_avail_q;
  assign w_addr_last = (r_acnt == ACNT_W'(ADDR_BYTES - 1));
  assign w_word_last = (w_pk_cnt == CNT_W'(DATA_BYTES - 1));
  assign w_timed     = (r_state == S_DEV) || (r_state == S_ADDR) || (r_state == S_WDATA);
  assign w_timeout   = w_timed && !r_byte_vld && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_last_word = (r_burst == '0);
  assign w_dev_ok_c  = (r_byte < 8'(NUM_DEV));
  // A strobe is never issued back to back, leaving one idle cycle between bytes
  assign w_tx_fire   = (r_state == S_RTX) && (w_pk_cnt != '0) && !iUartTxBusy && !r_tx_stb;
  assign w_tx_done   = (r_state == S_RTX) && (w_pk_cnt == '0);

  uart_word_packer #(.DATA_BYTES(DATA_BYTES)) u_packer (
    .i_clk       (iGlobalClock),
    .i_rst       (iGlobalReset),
    .i_clear     (w_pk_clear),
    .i_shift_in  (w_pk_shift_in),
    .i_load      (w_pk_load),
    .i_shift_out (w_tx_fire),
    .i_byte      (r_byte),
    .i_word      (iBusData),
    .o_word      (w_pk_word),
    .o_msb       (w_pk_msb),
    .o_cnt       (w_pk_cnt)
  );

  // State register
  always_ff @(posedge iGlobalClock) begin
    if (iGlobalReset) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state logic; a timeout overrides everything in the frame-receiving states
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (r_byte_vld) w_state_nxt = S_DEV;
        S_DEV:   if (r_byte_vld) w_state_nxt = S_ADDR;
        S_ADDR:
          if (r_byte_vld && w_addr_last) begin
            if (r_op == UART_WRITE) w_state_nxt = S_WDATA;
            else if (r_dev_ok)      w_state_nxt = S_RBUS;
            else                    w_state_nxt = S_IDLE;
          end
        S_WDATA:
          if (r_byte_vld && w_word_last) begin
            if (r_dev_ok)         w_state_nxt = S_WBUS;
            else if (w_last_word) w_state_nxt = S_IDLE;
          end
        S_WBUS:  if (iBusAck) w_state_nxt = w_last_word ? S_IDLE : S_WDATA;
        S_RBUS:  if (iBusAck) w_state_nxt = S_RTX;
        S_RTX:   if (w_tx_done) w_state_nxt = w_last_word ? S_IDLE : S_RBUS;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Per-state control decode for the datapath and the packer
  always_comb begin
    w_err_c       = 1'b0;
    w_pk_clear    = 1'b0;
    w_pk_shift_in = 1'b0;
    w_pk_load     = 1'b0;
    w_word_done   = 1'b0;
    if (w_timeout) w_err_c = 1'b1;
    if (r_byte_vld && ((r_state == S_WBUS) || (r_state == S_RBUS) || (r_state == S_RTX)))
      w_err_c = 1'b1;
    if ((r_state == S_DEV) && r_byte_vld && !w_dev_ok_c) w_err_c = 1'b1;
    if ((w_state_nxt == S_WDATA) && (r_state != S_WDATA)) w_pk_clear = 1'b1;
    if ((r_state == S_WDATA) && r_byte_vld) begin
      w_pk_shift_in = 1'b1;
      // Unselected device: swallow the word without a bus request
      if (w_word_last && !r_dev_ok) begin
        w_pk_clear  = 1'b1;
        w_word_done = 1'b1;
      end
    end
    if ((r_state == S_RBUS) && iBusAck) w_pk_load = 1'b1;
    if (((r_state == S_WBUS) && iBusAck) || w_tx_done) w_word_done = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge iGlobalClock) begin
    if (iGlobalReset) begin
      r_avail_q  <= 1'b1;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_op       <= UART_READ;
      r_burst    <= '0;
      r_dev      <= '0;
      r_dev_ok   <= 1'b0;
      r_acnt     <= '0;
      r_addr     <= '0;
      r_timer    <= '0;
      r_tx_stb   <= 1'b0;
      r_tx_byte  <= '0;
      r_bus_wr   <= 1'b0;
      r_bus_rd   <= 1'b0;
      r_devsel   <= '0;
      r_bus_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_avail_q  <= iUartByteAvailable;
      r_byte_vld <= w_rise;
      if (w_rise) r_byte <= iUartRx;
      r_timer <= (w_timed && !r_byte_vld) ? r_timer + TMR_W'(1) : '0;
      if ((r_state == S_IDLE) && r_byte_vld) begin
        r_op    <= r_byte[CMD_OP_BIT];
        r_burst <= r_byte[BURST_MSB:BURST_LSB];
      end
      if ((r_state == S_DEV) && r_byte_vld) begin
        r_dev    <= r_byte;
        r_dev_ok <= w_dev_ok_c;
        r_acnt   <= '0;
      end
      if ((r_state == S_ADDR) && r_byte_vld) begin
        r_addr <= ADDR_W'({r_addr, r_byte});
        r_acnt <= r_acnt + ACNT_W'(1);
      end
      if (w_word_done && !w_last_word) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_burst <= r_burst - BURST_W'(1);
      end
      if ((r_state == S_WDATA) && r_byte_vld && w_word_last && r_dev_ok)
        r_bus_data <= DATA_W'({w_pk_word, r_byte});
      r_bus_wr <= (w_state_nxt == S_WBUS);
      r_bus_rd <= (w_state_nxt == S_RBUS);
      r_devsel <= ((w_state_nxt == S_WBUS) || (w_state_nxt == S_RBUS)) ?
                  (NUM_DEV'(1) << r_dev) : '0;
      r_tx_stb <= w_tx_fire;
      if (w_tx_fire) r_tx_byte <= w_pk_msb;
      r_err <= w_err_c;
    end
  end

  assign oUartTx              = r_tx_byte;
  assign oUartTxByteAvailable = r_tx_stb;
  assign oBusWrite            = r_bus_wr;
  assign oBusRead             = r_bus_rd;
  assign oBusDevSel           = r_devsel;
  assign oBusAddr             = r_addr;
  assign oBusData             = r_bus_data;
  assign oError               = r_err;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_cmd_bridge;

  localparam int NUM_DEV = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avail = 1'b0;
  logic [7:0]  rx = 8'h00;
  logic        busy = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [7:0]  tx;
  logic        tx_stb, bus_wr, bus_rd, err;
  logic [3:0]  devsel;
  logic [15:0] bus_addr;
  logic [31:0] bus_data;

  always #5 clk = ~clk;

  uart_cmd_bridge dut (
    .iGlobalClock         (clk),
    .iGlobalReset         (rst),
    .iUartByteAvailable   (avail),
    .iUartRx              (rx),
    .oUartTx              (tx),
    .oUartTxByteAvailable (tx_stb),
    .iUartTxBusy          (busy),
    .oBusWrite            (bus_wr),
    .oBusRead             (bus_rd),
    .oBusDevSel           (devsel),
    .oBusAddr             (bus_addr),
    .oBusData             (bus_data),
    .iBusData             (bus_rdata),
    .iBusAck              (ack),
    .oError               (err)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        bus_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  pl_q[$];
  int n_checks = 0, n_err = 0, err_cnt = 0;
  int overlap = 0, gap_viol = 0, busy_viol = 0, unstable = 0, late_drop = 0;
  int hold_cmd = 1;
  bit ack_en = 1'b1;
  bit prev_stb = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: TX bytes, error pulses and protocol rules
  always @(negedge clk) begin
    if (tx_stb) begin
      tx_q.push_back(tx);
      if (busy) busy_viol++;
      if (prev_stb) gap_viol++;
      if (bus_wr || bus_rd) overlap++;
    end
    prev_stb = tx_stb;
    if (err) err_cnt++;
  end

  // Bus slave: logs each request, checks it stays stable, acks after a random delay
  txn_t rt;
  int   rd_dly, rd_wait;
  always begin
    @(negedge clk);
    if (bus_wr || bus_rd) begin
      rt.wr   = bus_wr;
      rt.sel  = devsel;
      rt.addr = bus_addr;
      rt.data = bus_wr ? bus_data : ((rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF);
      rd_dly  = $urandom_range(0, 4);
      rd_wait = 0;
      while ((bus_wr || bus_rd) && (rd_wait < rd_dly || !ack_en)) begin
        if (bus_addr !== rt.addr || devsel !== rt.sel || (rt.wr && bus_data !== rt.data) ||
            bus_wr !== rt.wr) unstable++;
        @(negedge clk);
        rd_wait++;
      end
      if (bus_wr || bus_rd) begin
        bus_q.push_back(rt);
        bus_rdata = rt.data;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (bus_wr || bus_rd) late_drop++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    rx = b;
    avail = 1'b1;
    repeat (hold) @(posedge clk);
    #1 avail = 1'b0;
    @(posedge clk);
  endtask

  task automatic fill_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame-level reference: words = CMD[6:0]+1, consecutive wrapping addresses,
  // big-endian data, one error and nothing else for an unknown device.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dev,
                           input logic [15:0] addr, input string tag);
    int          words, e0, guard;
    bit          wr, ok;
    txn_t        exp_q[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] rd_exp[$];
    txn_t        t;
    words  = int'(cmd & 8'h7F) + 1;
    wr     = cmd[7];
    ok     = (int'(dev) < NUM_DEV);
    rd_exp = rd_q;
    if (ok) begin
      for (int i = 0; i < words; i++) begin
        t.wr   = wr;
        t.sel  = 4'(32'd1 << dev);
        t.addr = 16'(int'(addr) + i);
        if (wr) t.data = (32'(pl_q[4*i]) << 24) | (32'(pl_q[4*i+1]) << 16) |
                         (32'(pl_q[4*i+2]) << 8) | 32'(pl_q[4*i+3]);
        else begin
          t.data = rd_exp[i];
          for (int k = 3; k >= 0; k--) exp_tx.push_back(8'((rd_exp[i] >> (8 * k)) & 32'hFF));
        end
        exp_q.push_back(t);
      end
    end
    bus_q.delete();
    tx_q.delete();
    e0 = err_cnt;
    send_byte(cmd, hold_cmd);
    send_byte(dev, 1);
    send_byte(addr[15:8], 1);
    send_byte(addr[7:0], 1);
    if (wr) begin
      for (int i = 0; i < words; i++) begin
        guard = 0;
        while (ok && i > 0 && (bus_q.size() < i || bus_wr) && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        for (int k = 0; k < 4; k++) send_byte(pl_q[4*i+k], 1);
      end
    end
    guard = 0;
    while ((bus_q.size() < exp_q.size() || tx_q.size() < exp_tx.size()) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_nbus"}, 64'(bus_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) begin
      check($sformatf("%s_ctl%0d", tag, i), 64'({bus_q[i].wr, bus_q[i].sel, bus_q[i].addr}),
            64'({exp_q[i].wr, exp_q[i].sel, exp_q[i].addr}));
      check($sformatf("%s_data%0d", tag, i), 64'(bus_q[i].data), 64'(exp_q[i].data));
    end
    check({tag, "_ntx"}, 64'(tx_q.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 64'(tx_q[i]), 64'(exp_tx[i]));
    check({tag, "_err"}, 64'(err_cnt - e0), ok ? 64'd0 : 64'd1);
    pl_q.delete();
  endtask

  initial begin
    int          e0, lat, guard;
    logic [7:0]  cmd, dev;
    logic [15:0] addr;

    // Reset with the RX level already high; it must not count as a byte
    rst = 1'b1; avail = 1'b1; rx = 8'h80;
    repeat (4) @(negedge clk);
    check("rst_outputs", {tx, tx_stb, bus_wr, bus_rd, devsel, bus_addr, bus_data, err}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 avail = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_err", 64'(err_cnt), 64'd0);

    // Single write 'HOLA' to dev 1, CMD held high for 10 cycles
    pl_q = '{8'h48, 8'h4F, 8'h4C, 8'h41};
    hold_cmd = 10;
    run_frame(8'h80, 8'h01, 16'h0007, "wr_hola");
    hold_cmd = 1;

    // Single read with the transmitter busy for 20 cycles after the bus ack
    rd_q.delete();
    rd_q.push_back(32'h484F4C41);
    busy = 1'b1;
    bus_q.delete();
    fork
      run_frame(8'h00, 8'h01, 16'h0007, "rd_hola");
      begin
        guard = 0;
        while (bus_q.size() < 1 && guard < 500) begin @(negedge clk); guard++; end
        repeat (20) @(negedge clk);
        check("rd_busy_hold", 64'(tx_q.size()), 64'd0);
        busy = 1'b0;
      end
    join

    // Two-word burst wrapping from 0xFFFF to 0x0000
    fill_payload(8);
    run_frame(8'h81, 8'h02, 16'hFFFF, "wr_wrap");

    // Unknown device: payload consumed, no request; next frame must still work
    fill_payload(4);
    run_frame(8'h80, 8'h09, 16'h0100, "wr_baddev");
    fill_payload(4);
    run_frame(8'h80, 8'h03, 16'h0200, "wr_after_bad");
    run_frame(8'h01, 8'h07, 16'h0300, "rd_baddev");

    // Inter-byte timeout after two data bytes
    bus_q.delete();
    e0 = err_cnt;
    send_byte(8'h80, 1); send_byte(8'h00, 1); send_byte(8'h12, 1); send_byte(8'h34, 1);
    send_byte(8'hAA, 1); send_byte(8'hBB, 1);
    lat = 0;
    while (err_cnt == e0 && lat < 3000) begin @(negedge clk); lat++; end
    check("timeout_window", 64'((lat >= TIMEOUT - 10) && (lat <= TIMEOUT + 10)), 64'd1);
    repeat (5) @(negedge clk);
    check("timeout_err", 64'(err_cnt - e0), 64'd1);
    check("timeout_nbus", 64'(bus_q.size()), 64'd0);
    fill_payload(4);
    run_frame(8'h80, 8'h00, 16'h1234, "wr_after_to");

    // Held write request: a stray byte is dropped with an error, then reset aborts it
    ack_en = 1'b0;
    bus_q.delete();
    send_byte(8'h80, 1); send_byte(8'h03, 1); send_byte(8'h00, 1); send_byte(8'h10, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    guard = 0;
    while (!bus_wr && guard < 200) begin @(negedge clk); guard++; end
    check("hold_req", 64'({bus_wr, devsel, bus_addr, bus_data}),
          64'({1'b1, 4'b1000, 16'h0010, 32'h11223344}));
    e0 = err_cnt;
    send_byte(8'h55, 1);
    repeat (4) @(negedge clk);
    check("stray_err", 64'(err_cnt - e0), 64'd1);
    check("stray_req_held", 64'(bus_wr), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wbus", {tx_stb, bus_wr, bus_rd, devsel, bus_addr, bus_data, err}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    ack_en = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_ack", 64'(bus_q.size()), 64'd0);
    check("rst_no_req", 64'({bus_wr, bus_rd}), 64'd0);

    // Randomized frames against the reference model
    for (int n = 0; n < 20; n++) begin
      cmd  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 2))};
      dev  = 8'($urandom_range(0, 5));
      addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if (cmd[7]) fill_payload(4 * (int'(cmd[6:0]) + 1));
      else if (int'(dev) < NUM_DEV)
        for (int i = 0; i <= int'(cmd[6:0]); i++) rd_q.push_back($urandom);
      run_frame(cmd, dev, addr, $sformatf("rnd%0d", n));
    end

    check("tx_bus_overlap", 64'(overlap), 64'd0);
    check("tx_gap", 64'(gap_viol), 64'd0);
    check("tx_while_busy", 64'(busy_viol), 64'd0);
    check("req_stable", 64'(unstable), 64'd0);
    check("req_drop_after_ack", 64'(late_drop), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
